// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_word block.
// The state enum doubles as the IDLE/SHIFT encoding constants.
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Fill bit used to build the default reset value of the shift word.
    localparam logic RESET_FILL = 1'b1;

endpackage

// File: rtl/shift_tick_div.sv
// Shift-rate divider: emits one tick every SHIFT_DIV running cycles.
// The count freezes under hold and clears whenever the transfer is not running.
module shift_tick_div #(
    parameter int SHIFT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    assign tick = run && !hold && (r_div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (!run) begin
            r_div_cnt <= '0;
        end else if (!hold) begin
            r_div_cnt <= tick ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/shift_word.sv
// WIDTH-bit shift word with parallel load and a start/busy/done handshake
// that shifts a full word out on ser_out while capturing ser_in.
module shift_word
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter bit               LSB_FIRST = 1'b0,
    parameter int               SHIFT_DIV = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{RESET_FILL}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic             hold,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_done;
    logic             w_run;
    logic             w_tick;
    logic             w_last;
    logic [WIDTH-1:0] w_word_shifted;

    assign w_run  = (r_state == ST_SHIFT);
    assign w_last = w_tick && (r_bit_cnt == BIT_LAST);

    shift_tick_div #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .hold (hold),
        .tick (w_tick)
    );

    // Outgoing bit leaves one end while the sampled ser_in enters the other.
    assign w_word_shifted = LSB_FIRST ? {ser_in, r_word[WIDTH-1:1]}
                                      : {r_word[WIDTH-2:0], ser_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default comes first so every path assigns the next state and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= RESET_VAL;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (r_state == ST_IDLE) begin
                // A simultaneous load and start transfers the freshly loaded word.
                if (load)  r_word    <= par_in;
                if (start) r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_word    <= w_word_shifted;
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + BIT_W'(1);
            end
        end
    end

    assign ser_out = LSB_FIRST ? r_word[0] : r_word[WIDTH-1];
    assign par_out = r_word;
    assign busy    = w_run;
    assign done    = r_done;

endmodule

// File: tb/tb_shift_word.sv
// Self-checking bench for shift_word: three 8-bit instances (MSB-first, LSB-first,
// divide-by-3) share stimulus and are compared every cycle against a transfer-level model.
module tb_shift_word;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       load   = 1'b0;
    logic       start  = 1'b0;
    logic       hold   = 1'b0;
    logic       ser_in = 1'b0;
    logic [7:0] par_in = 8'h00;

    logic [7:0] par_out [3];
    logic       ser_out [3];
    logic       busy    [3];
    logic       done    [3];

    shift_word #(.WIDTH(8), .LSB_FIRST(1'b0), .SHIFT_DIV(1)) u_msb (
        .clk(clk), .rst(rst), .load(load), .par_in(par_in), .start(start), .hold(hold),
        .ser_in(ser_in), .ser_out(ser_out[0]), .par_out(par_out[0]), .busy(busy[0]), .done(done[0]));

    shift_word #(.WIDTH(8), .LSB_FIRST(1'b1), .SHIFT_DIV(1)) u_lsb (
        .clk(clk), .rst(rst), .load(load), .par_in(par_in), .start(start), .hold(hold),
        .ser_in(ser_in), .ser_out(ser_out[1]), .par_out(par_out[1]), .busy(busy[1]), .done(done[1]));

    shift_word #(.WIDTH(8), .LSB_FIRST(1'b0), .SHIFT_DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .load(load), .par_in(par_in), .start(start), .hold(hold),
        .ser_in(ser_in), .ser_out(ser_out[2]), .par_out(par_out[2]), .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer is a count of non-held cycles; every
    // SHIFT_DIV of them is one bit step, and the eighth step ends the transfer.
    int         divs [3] = '{1, 1, 3};
    bit         lsbs [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_word [3] = '{8'hFF, 8'hFF, 8'hFF};
    bit         m_busy [3] = '{1'b0, 1'b0, 1'b0};
    bit         m_done [3] = '{1'b0, 1'b0, 1'b0};
    int         m_act  [3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_word[i] = 8'hFF;
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_act[i]  = 0;
            end else if (!m_busy[i]) begin
                m_done[i] = 1'b0;
                if (load)  m_word[i] = par_in;
                if (start) begin
                    m_busy[i] = 1'b1;
                    m_act[i]  = 0;
                end
            end else begin
                m_done[i] = 1'b0;
                if (!hold) begin
                    m_act[i]++;
                    if (m_act[i] % divs[i] == 0) begin
                        m_word[i] = lsbs[i] ? {ser_in, m_word[i][7:1]} : {m_word[i][6:0], ser_in};
                        if (m_act[i] / divs[i] == 8) begin
                            m_busy[i] = 1'b0;
                            m_done[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("par_out[%0d]", i), 32'(par_out[i]), 32'(m_word[i]));
                check($sformatf("ser_out[%0d]", i), 32'(ser_out[i]),
                      32'(lsbs[i] ? m_word[i][0] : m_word[i][7]));
                check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_busy[i]));
                check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_par_out[%0d]", tag, i), 32'(par_out[i]), 32'h0000_00FF);
            check($sformatf("%s_ser_out[%0d]", tag, i), 32'(ser_out[i]), 32'h1);
            check($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 32'h0);
            check($sformatf("%s_done[%0d]", tag, i), 32'(done[i]), 32'h0);
        end
    endtask

    // Starts a transfer at the current negedge; bits[7] is the first ser_in bit.
    // lat is the edge count from the start edge to the edge raising done[watch].
    task automatic xfer(input logic [7:0] bits, input int div, input int watch,
                        input int hold_at, input int hold_len, input bit chain,
                        input int busy_load_at, output int lat,
                        output logic [7:0] seq0, output logic [7:0] seq1);
        int idx;
        lat   = -1;
        seq0  = 8'h00;
        seq1  = 8'h00;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            load  = 1'b0;
            if (k <= 8) begin
                seq0[8-k] = ser_out[0];
                seq1[8-k] = ser_out[1];
            end
            if (done[watch]) begin
                lat = k - 1;
                break;
            end
            idx    = 7 - (((k - 1) / div) % 8);
            ser_in = bits[idx];
            hold   = (k >= hold_at) && (k < hold_at + hold_len);
            if (k == busy_load_at) begin
                load   = 1'b1;
                par_in = 8'hFF;
            end
        end
        hold = 1'b0;
        load = 1'b0;
        if (lat < 0) check("xfer_timeout", 32'h1, 32'h0);
        if (chain && lat >= 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("chain_busy", 32'(busy[watch]), 32'h1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || busy[2] || done[0] || done[1] || done[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'h1);
    endtask

    initial begin
        int         lat;
        logic [7:0] seq0;
        logic [7:0] seq1;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        cmp_en = 1'b1;
        rst    = 1'b0;

        // MSB-first and LSB-first transfers of 8'hA5, SHIFT_DIV=1.
        @(negedge clk);
        load   = 1'b1;
        par_in = 8'hA5;
        @(negedge clk);
        load   = 1'b0;
        xfer(8'b1011_0010, 1, 0, 0, 0, 1'b0, 0, lat, seq0, seq1);
        check("msb_done_latency", 32'(lat), 32'd8);
        check("msb_ser_out_seq", 32'(seq0), 32'h0000_00A5);
        check("lsb_ser_out_seq", 32'(seq1), 32'h0000_00A5);
        check("msb_par_out_final", 32'(par_out[0]), 32'h0000_00B2);
        check("lsb_par_out_final", 32'(par_out[1]), 32'h0000_004D);
        wait_idle();

        // Divide-by-3 with four hold cycles in the middle of the transfer.
        load   = 1'b1;
        par_in = 8'hA5;
        @(negedge clk);
        load   = 1'b0;
        xfer(8'b1011_0010, 3, 2, 5, 4, 1'b0, 0, lat, seq0, seq1);
        check("div3_hold_done_latency", 32'(lat), 32'd28);
        wait_idle();

        // Load with start, ignored load while busy, restart in the done cycle.
        load   = 1'b1;
        par_in = 8'h3C;
        xfer(8'b0101_1010, 1, 0, 0, 0, 1'b1, 4, lat, seq0, seq1);
        check("load_start_latency", 32'(lat), 32'd8);
        check("load_start_ser_out_seq", 32'(seq0), 32'h0000_003C);
        check("load_start_lsb_seq", 32'(seq1), 32'h0000_003C);
        wait_idle();

        // Reset mid-transfer takes effect without a clock edge.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
